// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem req/ack, 2-entry
// instruction queue toward decode, redirect flush with drop of an abandoned fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  op_out,
    output logic [5:0]  func_out
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t       state, state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  drop_addr;
    entry_t [1:0] q;
    logic [1:0]   count, count_nxt;
    logic         deq, enq, wr_idx;

    assign id_valid = (count != 2'd0);
    assign deq      = id_valid && id_ready;
    // Only a live fetch completing in REQ fills the queue; a redirect kills it.
    assign enq      = (state == REQ) && imem_ack && !redirect_valid;
    // Slot for the incoming word, after any same-cycle dequeue has shifted the head.
    assign wr_idx   = count[0] & ~deq;

    always_comb begin
        count_nxt = count + {1'b0, enq} - {1'b0, deq};
        if (redirect_valid)
            count_nxt = 2'd0;
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        case (state)
            IDLE: begin
                if (count_nxt != 2'd2)
                    state_nxt = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect_valid)
                    state_nxt = imem_ack ? REQ : DROP;
                else if (imem_ack)
                    state_nxt = (count_nxt == 2'd2) ? IDLE : REQ;
            end
            DROP: begin
                // The abandoned request must keep its address until memory answers.
                imem_req  = 1'b1;
                imem_addr = drop_addr;
                if (imem_ack)
                    state_nxt = (count_nxt == 2'd2) ? IDLE : REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            count     <= 2'd0;
            q         <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (redirect_valid)
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (enq)
                fetch_pc <= fetch_pc + 32'd4;
            if ((state == REQ) && redirect_valid && !imem_ack)
                drop_addr <= fetch_pc;
            if (!redirect_valid) begin
                if (deq)
                    q[0] <= q[1];
                if (enq)
                    q[wr_idx] <= '{instr: imem_rdata, pc: fetch_pc};
            end
        end
    end

    // An empty queue presents an all-zero NOP to the decoder.
    assign id_instr    = id_valid ? q[0].instr : 32'h0;
    assign id_pc       = q[0].pc;
    assign id_pc_plus4 = q[0].pc + 32'd4;
    assign op_out      = id_instr[31:26];
    assign func_out    = id_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a latency-configurable memory model pushes
// expected queue entries on accepted acks; entries are compared as decode pops them.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, imem_req, imem_ack, redirect_valid, id_valid, id_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc, id_pc_plus4;
    logic [5:0]  op_out, func_out;

    logic        reset2, imem_req2, imem_ack2, id_valid2;
    logic [31:0] imem_addr2, imem_rdata2, id_instr2, id_pc2, id_pc_plus4_2;
    logic [5:0]  op_out2, func_out2;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .op_out(op_out), .func_out(func_out)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .id_valid(id_valid2), .id_ready(1'b0),
        .id_instr(id_instr2), .id_pc(id_pc2), .id_pc_plus4(id_pc_plus4_2),
        .op_out(op_out2), .func_out(func_out2)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    ent_t        sb[$];
    int          lat = 0, wcnt = 0, pops = 0;
    bit          busy = 0, stale = 0, redir_d = 0;
    logic [31:0] req_addr = '0, exp_pc = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h300) return 32'h0000_0000;
        if (a == 32'h304) return 32'h2108_0020;
        return a;
    endfunction

    task automatic cycle();
        ent_t e;
        @(negedge clk);
        imem_ack = 1'b0;
        if (reset) begin
            busy = 0; stale = 0; redir_d = 0; exp_pc = 32'h0;
            sb.delete();
        end else begin
            if (redir_d) chk("valid_after_redirect", 32'(id_valid), 32'h0);
            if (!id_valid) begin
                chk("nop_instr", id_instr, 32'h0);
                chk("nop_op", 32'(op_out), 32'h0);
                chk("nop_func", 32'(func_out), 32'h0);
            end else if (id_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    pops++;
                    chk("id_pc", id_pc, e.pc);
                    chk("id_instr", id_instr, e.instr);
                    chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
                    chk("op_out", 32'(op_out), 32'(e.instr[31:26]));
                    chk("func_out", 32'(func_out), 32'(e.instr[5:0]));
                end
            end
            if (imem_req) begin
                if (!busy) begin
                    busy = 1; wcnt = lat; req_addr = imem_addr;
                    chk("fetch_addr", imem_addr, exp_pc);
                end else
                    chk("addr_stable", imem_addr, req_addr);
                if (wcnt == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_data(req_addr);
                end else
                    wcnt--;
            end
            if (redirect_valid) begin
                sb.delete();
                if (busy && !imem_ack) stale = 1;
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            if (imem_ack) begin
                if (!redirect_valid && !stale) begin
                    sb.push_back(ent_t'{imem_rdata, req_addr});
                    exp_pc += 32'd4;
                end
                busy = 0; stale = 0;
            end
            redir_d = redirect_valid;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        int found;
        reset = 1; imem_ack = 0; imem_rdata = 0; redirect_valid = 0; redirect_pc = 0;
        id_ready = 0; reset2 = 1; imem_ack2 = 0; imem_rdata2 = 0;

        // reset state
        cycle(); cycle();
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_pc_plus4", id_pc_plus4, 32'h4);
        chk("rst_op", 32'(op_out), 32'h0);
        chk("rst_func", 32'(func_out), 32'h0);

        // decode stalled: queue fills, requests stop, head holds
        reset = 0;
        repeat (6) cycle();
        chk("full_req", 32'(imem_req), 32'h0);
        chk("full_valid", 32'(id_valid), 32'h1);
        chk("full_pc", id_pc, 32'h0);
        cycle();
        chk("hold_pc", id_pc, 32'h0);
        chk("hold_plus4", id_pc_plus4, 32'h4);
        id_ready = 1;
        repeat (4) cycle();
        pops = 0;
        repeat (10) cycle();
        chk("throughput", 32'(pops), 32'd10);

        // redirect while a slow fetch is outstanding
        do_reset();
        lat = 3;
        for (int i = 0; i < 60 && !(imem_req && imem_addr == 32'h8 && busy); i++) cycle();
        chk("reach_0x8", imem_addr, 32'h8);
        redirect(32'h100);
        chk("drop_req", 32'(imem_req), 32'h1);
        chk("drop_addr", imem_addr, 32'h8);
        for (int i = 0; i < 30 && !id_valid; i++) cycle();
        chk("first_pc_0x100", id_pc, 32'h100);

        // redirect coinciding with a zero-wait ack
        lat = 0;
        for (int i = 0; i < 30 && !(imem_req && !busy); i++) cycle();
        redirect(32'h203);
        chk("redir_ack_req", 32'(imem_req), 32'h1);
        chk("redir_ack_addr", imem_addr, 32'h200);
        for (int i = 0; i < 20 && !id_valid; i++) cycle();
        chk("first_pc_0x200", id_pc, 32'h200);

        // opcode/function fields
        redirect(32'h300);
        for (int i = 0; i < 20 && !id_valid; i++) cycle();
        chk("nopw_pc", id_pc, 32'h300);
        chk("nopw_op", 32'(op_out), 32'h0);
        chk("nopw_func", 32'(func_out), 32'h0);
        cycle();
        w = 32'h2108_0020;
        chk("addw_pc", id_pc, 32'h304);
        chk("addw_op", 32'(op_out), 32'(w[31:26]));
        chk("addw_func", 32'(func_out), 32'(w[5:0]));
        repeat (5) cycle();

        // reset during a pending request
        lat = 5;
        do_reset();
        for (int i = 0; i < 20 && !(imem_req && busy); i++) cycle();
        chk("pend_req", 32'(imem_req), 32'h1);
        reset = 1;
        cycle();
        chk("midrst_req", 32'(imem_req), 32'h0);
        chk("midrst_valid", 32'(id_valid), 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        reset = 0;
        lat = 1;
        repeat (10) cycle();

        // PC wrap from RESET_PC = 0xFFFF_FFFC
        reset2 = 0;
        found = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (imem_req2) begin found = 1; break; end
        end
        chk("wrap_req", 32'(found), 32'h1);
        chk("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        imem_ack2 = 1; imem_rdata2 = 32'h1234_5678;
        @(posedge clk); #1;
        imem_ack2 = 0;
        @(negedge clk);
        chk("wrap_valid", 32'(id_valid2), 32'h1);
        chk("wrap_pc", id_pc2, 32'hFFFF_FFFC);
        chk("wrap_plus4", id_pc_plus4_2, 32'h0);
        chk("wrap_next_addr", imem_addr2, 32'h0);
        chk("wrap_instr", id_instr2, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
